// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - FSM encoding, opcode classes, condition codes and opcode classifier for the instruction sequencer
package seq_pkg;

    localparam logic [1:0] ST_FETCH    = 2'd0;
    localparam logic [1:0] ST_EXEC     = 2'd1;
    localparam logic [1:0] ST_EXEC2    = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

    localparam logic [1:0] PHASE_FIRST  = 2'b00;
    localparam logic [1:0] PHASE_SECOND = 2'b01;

    localparam logic [2:0] CLS_ILLEGAL = 3'd0;
    localparam logic [2:0] CLS_ALU     = 3'd1;
    localparam logic [2:0] CLS_B       = 3'd2;
    localparam logic [2:0] CLS_BL      = 3'd3;
    localparam logic [2:0] CLS_BCOND   = 3'd4;
    localparam logic [2:0] CLS_CBZ     = 3'd5;
    localparam logic [2:0] CLS_CBNZ    = 3'd6;
    localparam logic [2:0] CLS_LDST    = 3'd7;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // opc is ir[31:21]; branch formats are matched before the wider ALU/memory fields
    function automatic logic [2:0] classify(input logic [10:0] opc);
        logic [2:0] cls;
        cls = CLS_ILLEGAL;
        if (opc[10:5] == OP_B)
            cls = CLS_B;
        else if (opc[10:5] == OP_BL)
            cls = CLS_BL;
        else if (opc[10:3] == OP_BCOND)
            cls = CLS_BCOND;
        else if (opc[10:3] == OP_CBZ)
            cls = CLS_CBZ;
        else if (opc[10:3] == OP_CBNZ)
            cls = CLS_CBNZ;
        else if ((opc == OP_LDUR) || (opc == OP_STUR))
            cls = CLS_LDST;
        else begin
            casez (opc)
                11'b10001011000, 11'b10101011000, 11'b11001011000, 11'b11101011000,
                11'b10001010000, 11'b11101010000, 11'b10101010000, 11'b11001010000,
                11'b11010011011, 11'b11010011010, 11'b10011011000,
                11'b1001000100?, 11'b1011000100?, 11'b1101000100?, 11'b1111000100?,
                11'b1001001000?, 11'b1111001000?, 11'b1011001000?, 11'b1101001000?,
                11'b110100101??, 11'b111100101??:
                    cls = CLS_ALU;
                default:
                    cls = CLS_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch condition evaluator against NZCV flags
module cond_eval
    import seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       taken
);

    logic w_n, w_z, w_c, w_v;
    logic w_base;
    logic w_supported;

    assign {w_n, w_z, w_c, w_v} = status;

    // cond[3:1] picks the base test, cond[0] inverts it
    always_comb begin
        w_base = 1'b0;
        case (cond[3:1])
            3'b000:  w_base = w_z;
            3'b001:  w_base = w_c;
            3'b010:  w_base = w_n;
            3'b101:  w_base = (w_n == w_v);
            3'b110:  w_base = !w_z && (w_n == w_v);
            3'b111:  w_base = 1'b1;
            default: w_base = 1'b0;
        endcase
    end

    assign w_supported = (cond <= COND_PL) || ((cond >= COND_GE) && (cond <= COND_AL));
    assign taken       = w_supported && (w_base ^ cond[0]);

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute sequencer; SEQ_MEM_WAIT_EN adds a MEM_WAIT state for LDUR/STUR
module instr_sequencer
    import seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    input  logic        mem_ready,
    input  logic [3:0]  status,
    input  logic        alu_zero,
    output logic [31:0] ir,
    output logic [1:0]  state,
    output logic        decode_en,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        mem_req,
    output logic        retire,
    output logic        illegal
);

    logic [1:0]  r_fsm;
    logic [1:0]  r_phase;
    logic [31:0] r_ir;

    logic [1:0]  w_fsm_next;
    logic [2:0]  w_cls;
    logic        w_cond_taken;
    logic        w_decode_en, w_ir_load, w_pc_inc, w_pc_load, w_mem_req, w_retire, w_illegal;

    assign w_cls = classify(r_ir[31:21]);

    cond_eval u_cond_eval (
        .cond   (r_ir[3:0]),
        .status (status),
        .taken  (w_cond_taken)
    );

`ifndef SEQ_MEM_WAIT_EN
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
`endif

    always_comb begin
        w_fsm_next  = r_fsm;
        w_decode_en = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_mem_req   = 1'b0;
        w_retire    = 1'b0;
        w_illegal   = 1'b0;
        case (r_fsm)
            ST_FETCH: begin
                if (imem_valid) begin
                    w_ir_load  = 1'b1;
                    w_fsm_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_decode_en = 1'b1;
                w_fsm_next  = ST_FETCH;
                case (w_cls)
                    CLS_ALU: begin
                        w_pc_inc = 1'b1;
                        w_retire = 1'b1;
                    end
                    CLS_B: begin
                        w_pc_load = 1'b1;
                        w_retire  = 1'b1;
                    end
                    CLS_BCOND: begin
                        w_pc_load = w_cond_taken;
                        w_pc_inc  = !w_cond_taken;
                        w_retire  = 1'b1;
                    end
                    CLS_CBZ: begin
                        w_pc_load = alu_zero;
                        w_pc_inc  = !alu_zero;
                        w_retire  = 1'b1;
                    end
                    CLS_CBNZ: begin
                        w_pc_load = !alu_zero;
                        w_pc_inc  = alu_zero;
                        w_retire  = 1'b1;
                    end
                    CLS_BL: begin
                        w_fsm_next = ST_EXEC2;
                    end
                    CLS_LDST: begin
                        w_mem_req = 1'b1;
`ifdef SEQ_MEM_WAIT_EN
                        w_fsm_next = ST_MEM_WAIT;
`else
                        w_fsm_next = ST_EXEC2;
`endif
                    end
                    default: begin
                        w_illegal = 1'b1;
                        w_pc_inc  = 1'b1;
                    end
                endcase
            end
            // second phase: BL branches, LDUR/STUR (single-cycle memory) completes
            ST_EXEC2: begin
                w_decode_en = 1'b1;
                w_retire    = 1'b1;
                w_fsm_next  = ST_FETCH;
                if (w_cls == CLS_LDST) begin
                    w_mem_req = 1'b1;
                    w_pc_inc  = 1'b1;
                end else begin
                    w_pc_load = 1'b1;
                end
            end
`ifdef SEQ_MEM_WAIT_EN
            ST_MEM_WAIT: begin
                w_decode_en = 1'b1;
                w_mem_req   = 1'b1;
                if (mem_ready) begin
                    w_pc_inc   = 1'b1;
                    w_retire   = 1'b1;
                    w_fsm_next = ST_FETCH;
                end
            end
`endif
            default: begin
                w_fsm_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm   <= ST_FETCH;
            r_phase <= PHASE_FIRST;
            r_ir    <= 32'h0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_phase <= ((w_fsm_next == ST_EXEC2) || (w_fsm_next == ST_MEM_WAIT)) ? PHASE_SECOND : PHASE_FIRST;
            if (w_ir_load)
                r_ir <= imem_data;
        end
    end

    assign ir        = r_ir;
    assign state     = r_phase;
    assign decode_en = w_decode_en && !reset;
    assign ir_load   = w_ir_load   && !reset;
    assign pc_inc    = w_pc_inc    && !reset;
    assign pc_load   = w_pc_load   && !reset;
    assign mem_req   = w_mem_req   && !reset;
    assign retire    = w_retire    && !reset;
    assign illegal   = w_illegal   && !reset;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 SHALL have port: imem_data  in  32  instruction word from instruction memory.
REQ-004 SHALL have port: imem_valid  in  1  imem_data valid this cycle.
REQ-005 SHALL have port: mem_ready  in  1  data memory completed the access this cycle.
REQ-006 SHALL have port: status  in  4  NZCV flags {N,Z,C,V}, bit 3 = N.
REQ-007 SHALL have port: alu_zero  in  1  datapath ALU result == 0 (CBZ/CBNZ test).
REQ-008 SHALL have ports (outputs): ir 32 latched instruction; state 2 phase code to decode logic (00 first cycle, 01 second cycle); decode_en 1 control word valid; ir_load 1; pc_inc 1 (PC += 4); pc_load 1 (PC <= branch target); mem_req 1; retire 1 (one-cycle pulse per completed instruction); illegal 1 (pulse on unrecognised opcode).

Function
REQ-009 SHALL implement FSM states FETCH, EXEC, EXEC2, MEM_WAIT.
REQ-010 FETCH: SHALL assert ir_load in the same cycle imem_valid=1, capture imem_data into ir on that edge, go to EXEC; imem_valid=0 -> stay in FETCH, ir unchanged.
REQ-011 EXEC SHALL assert decode_en=1, state=00, for exactly one cycle.
REQ-012 Class decode on ir: B = ir[31:26]=000101; BL = 100101; B.cond = ir[31:24]=01010100; CBZ = 10110100; CBNZ = 10110101; LDUR = ir[31:21]=11111000010; STUR = 11111000000; all other recognised R/I/D/IW opcodes = ALU class.
REQ-013 ALU class in EXEC: pc_inc=1, retire=1, next FETCH (2-cycle instruction at imem_valid held high).
REQ-014 B in EXEC: pc_load=1, retire=1, next FETCH.
REQ-015 B.cond in EXEC: taken per cond_eval of ir[3:0] vs status -> pc_load=1, else pc_inc=1; retire=1; next FETCH.
REQ-016 Supported conditions: EQ 0000 (Z), NE 0001 (!Z), HS 0010 (C), LO 0011 (!C), MI 0100 (N), PL 0101 (!N), GE 1010 (N==V), LT 1011 (N!=V), GT 1100 (!Z&&N==V), LE 1101 (Z||N!=V), AL 1110 (1); any other code SHALL be treated as not taken.
REQ-017 CBZ/CBNZ in EXEC: taken when alu_zero=1 (CBZ) / alu_zero=0 (CBNZ); pc_load or pc_inc accordingly; retire=1; next FETCH.
REQ-018 BL: EXEC (state=00, link write, no PC strobe) -> EXEC2 (decode_en=1, state=01, pc_load=1, retire=1) -> FETCH.
REQ-019 LDUR/STUR: EXEC (state=00, mem_req=1) -> MEM_WAIT (decode_en=1, state=01, mem_req=1) until mem_ready=1; in that cycle pc_inc=1, retire=1, next FETCH.
REQ-020 mem_ready SHALL be ignored outside MEM_WAIT.
REQ-021 Unrecognised opcode in EXEC: illegal=1, pc_inc=1, retire=0, next FETCH.
REQ-022 pc_inc and pc_load SHALL never be asserted in the same cycle; ir_load SHALL only assert in FETCH.
REQ-023 All strobe outputs SHALL be combinational from FSM state and ir; ir and state register SHALL be flops.

Reset
REQ-024 reset=1 SHALL, at the next edge, force FSM to FETCH, ir=32'h0, state=00; all strobes 0 while reset is high.
REQ-025 reset SHALL override any state, including MEM_WAIT with mem_ready=1 and EXEC2; no retire pulse on that edge.

Configuration
REQ-026 Macro SEQ_MEM_WAIT_EN defined: LDUR/STUR behave per REQ-019.
REQ-027 SEQ_MEM_WAIT_EN undefined: MEM_WAIT state absent; LDUR/STUR go EXEC -> EXEC2 (state=01, mem_req=1, pc_inc=1, retire=1) -> FETCH; mem_ready unused.

Structure
REQ-028 Shared package seq_pkg SHALL hold FSM state encoding, opcode-class constants and condition-code constants.
REQ-029 Condition evaluation SHALL be a combinational sub-module cond_eval (in: cond[3:0], status[3:0]; out: taken).

Verification
REQ-030 ADD 0x8B030041, imem_valid=1: ir_load cycle 0, EXEC cycle 1 with decode_en=1, pc_inc=1, retire=1.
REQ-031 B.EQ 0x54000040 with status=0100 -> pc_load=1; repeat with status=0000 -> pc_inc=1.
REQ-032 BL 0x94000010: EXEC state=00 no PC strobe, EXEC2 state=01 pc_load=1 retire=1, then FETCH.
REQ-033 LDUR 0xF8408041, mem_ready low 3 cycles then high (macro defined): mem_req held 4 cycles, pc_inc+retire only in mem_ready cycle.
REQ-034 CBZ 0xB4000041 with alu_zero=1 -> pc_load; opcode 0x00000000 -> illegal=1, pc_inc=1, retire=0.
REQ-035 reset asserted in MEM_WAIT with mem_ready=1: next cycle FETCH, ir=0, no retire.
